// File: rtl/filter_env_pkg.sv
// filter_env_pkg
//   Shared types and helpers for the filter envelope generator.
//   - env_state_e : envelope state encoding (IDLE=0 .. RELEASE=4)
//   - LEVEL_MAX   : default envelope peak level
//   - sat16       : 18-bit signed to 16-bit signed saturation
//   - clamp_level : clamp a 17-bit signed level candidate to 0..max
package filter_env_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    localparam logic [15:0] LEVEL_MAX = 16'h7FFF;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    function automatic logic [15:0] clamp_level(input logic signed [16:0] v,
                                                input logic [15:0] max);
        if (v < 0) begin
            return '0;
        end else if (v > $signed({1'b0, max})) begin
            return max;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/env_cutoff_mac.sv
// env_cutoff_mac
//   Registered cutoff computation: sat16(base + ((level * amount) >>> 15)).
//   Ports:
//     clk, reset_n     : clock, asynchronous active-low reset
//     upd_i            : compute a new cutoff this cycle
//     level_i          : envelope level (unsigned, zero-extended into the product)
//     base_cutoff_i    : signed cutoff at level 0
//     env_amount_i     : signed modulation depth, Q1.15
//     cutoff_o         : registered saturated cutoff word
//     cutoff_valid_o   : one-cycle pulse when cutoff_o updates
module env_cutoff_mac
    import filter_env_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    upd_i,
    input  logic [WIDTH-1:0]        level_i,
    input  logic signed [WIDTH-1:0] base_cutoff_i,
    input  logic signed [WIDTH-1:0] env_amount_i,
    output logic signed [WIDTH-1:0] cutoff_o,
    output logic                    cutoff_valid_o
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH+1:0]   sum;
    logic signed [WIDTH-1:0]   cutoff_q;
    logic                      valid_q;

    always_comb begin
        prod = (2*WIDTH)'($signed({1'b0, level_i})) * (2*WIDTH)'(env_amount_i);
        // Scaled term fits in WIDTH+1 bits; the sum needs one more for headroom.
        sum  = (WIDTH+2)'(base_cutoff_i) + (WIDTH+2)'(prod >>> 15);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cutoff_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= upd_i;
            if (upd_i) begin
                cutoff_q <= sat16(sum);
            end
        end
    end

    assign cutoff_o       = cutoff_q;
    assign cutoff_valid_o = valid_q;

endmodule

// File: rtl/filter_envelope_gen.sv
// filter_envelope_gen
//   ADSR envelope generator driving the low-pass filter cutoff.
//   Ports:
//     clk, reset_n       : clock, asynchronous active-low reset
//     tick               : sample strobe; envelope steps only on tick
//     gate               : note gate (1 = key held); edges act on the next clk
//     attack_rate        : attack step per tick (bit 15 ignored)
//     decay_rate         : decay step per tick (bit 15 ignored)
//     sustain_level      : signed sustain target, negative clamps to 0
//     release_rate       : release step per tick (bit 15 ignored)
//     base_cutoff        : signed cutoff at envelope level 0
//     env_amount         : signed modulation depth, Q1.15
//     cutoff             : registered saturated cutoff word
//     cutoff_valid       : one-cycle pulse two cycles after tick
//     env_level          : current envelope level, 0..LEVEL_MAX
//     env_state          : current state encoding
//   Build option: FILTER_ENV_EXP_DECAY_EN makes DECAY/RELEASE steps exponential,
//   step = max(1, ((level - target) * rate) >> 15). ATTACK stays linear.
module filter_envelope_gen #(
    parameter int unsigned          WIDTH     = 16,
    parameter logic [WIDTH-1:0]     LEVEL_MAX = filter_env_pkg::LEVEL_MAX
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tick,
    input  logic                    gate,
    input  logic [WIDTH-1:0]        attack_rate,
    input  logic [WIDTH-1:0]        decay_rate,
    input  logic signed [WIDTH-1:0] sustain_level,
    input  logic [WIDTH-1:0]        release_rate,
    input  logic signed [WIDTH-1:0] base_cutoff,
    input  logic signed [WIDTH-1:0] env_amount,
    output logic signed [WIDTH-1:0] cutoff,
    output logic                    cutoff_valid,
    output logic [WIDTH-1:0]        env_level,
    output logic [2:0]              env_state
);
    import filter_env_pkg::*;

    env_state_e              state_q;
    logic [WIDTH-1:0]        level_q;
    logic                    gate_q;
    logic                    upd_q;

    logic                    rise, fall;
    logic [WIDTH-1:0]        target;
    logic [WIDTH-1:0]        dr_tgt;
    logic [14:0]             dr_rate;
    logic [WIDTH-1:0]        step;
    logic [WIDTH:0]          att_sum;
    logic                    att_peak;
    logic signed [WIDTH:0]   dr_diff;
    logic                    dr_done;
    logic                    unused_rate_msbs;

`ifdef FILTER_ENV_EXP_DECAY_EN
    logic [WIDTH-1:0]        diff;
    logic [2*WIDTH-1:0]      prod;
`endif

    assign unused_rate_msbs = ^{attack_rate[15], decay_rate[15], release_rate[15]};

    always_comb begin
        rise     = gate & ~gate_q;
        fall     = ~gate & gate_q;
        target   = clamp_level((WIDTH+1)'(sustain_level), LEVEL_MAX);
        att_sum  = {1'b0, level_q} + (WIDTH+1)'(attack_rate[14:0]);
        att_peak = att_sum >= {1'b0, LEVEL_MAX};

        // DECAY and RELEASE share one down-step path; only target and rate differ.
        if (state_q == ST_DECAY) begin
            dr_tgt  = target;
            dr_rate = decay_rate[14:0];
        end else begin
            dr_tgt  = '0;
            dr_rate = release_rate[14:0];
        end

`ifdef FILTER_ENV_EXP_DECAY_EN
        diff = (level_q > dr_tgt) ? level_q - dr_tgt : '0;
        prod = (2*WIDTH)'(diff) * (2*WIDTH)'(dr_rate);
        step = WIDTH'(prod >> 15);
        if (step == '0) begin
            step = WIDTH'(1);
        end
`else
        step = WIDTH'(dr_rate);
`endif

        dr_diff = $signed({1'b0, level_q}) - $signed({1'b0, step});
        dr_done = dr_diff <= $signed({1'b0, dr_tgt});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            gate_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            gate_q <= gate;
            upd_q  <= tick;
            // Gate edges take priority and suppress any step in the same cycle.
            if (rise) begin
                state_q <= ST_ATTACK;
            end else if (fall) begin
                if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN) begin
                    state_q <= ST_RELEASE;
                end
            end else if (tick) begin
                unique case (state_q)
                    ST_IDLE: level_q <= '0;
                    ST_ATTACK: begin
                        if (attack_rate[14:0] != '0) begin
                            if (att_peak) begin
                                level_q <= LEVEL_MAX;
                                state_q <= ST_DECAY;
                            end else begin
                                level_q <= att_sum[WIDTH-1:0];
                            end
                        end
                    end
                    ST_DECAY, ST_RELEASE: begin
                        if (dr_rate != '0) begin
                            if (dr_done) begin
                                level_q <= dr_tgt;
                                state_q <= (state_q == ST_DECAY) ? ST_SUSTAIN : ST_IDLE;
                            end else begin
                                level_q <= clamp_level(dr_diff, LEVEL_MAX);
                            end
                        end
                    end
                    ST_SUSTAIN: level_q <= target;
                    default: begin
                        state_q <= ST_IDLE;
                        level_q <= '0;
                    end
                endcase
            end
        end
    end

    env_cutoff_mac #(
        .WIDTH(WIDTH)
    ) u_mac (
        .clk            (clk),
        .reset_n        (reset_n),
        .upd_i          (upd_q),
        .level_i        (level_q),
        .base_cutoff_i  (base_cutoff),
        .env_amount_i   (env_amount),
        .cutoff_o       (cutoff),
        .cutoff_valid_o (cutoff_valid)
    );

    assign env_level = level_q;
    assign env_state = state_q;

endmodule

// File: tb/tb_filter_envelope_gen.sv
module tb_filter_envelope_gen;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               tick;
    logic               gate;
    logic [15:0]        attack_rate, decay_rate, release_rate;
    logic signed [15:0] sustain_level, base_cutoff, env_amount;
    logic signed [15:0] cutoff;
    logic               cutoff_valid;
    logic [15:0]        env_level;
    logic [2:0]         env_state;

    filter_envelope_gen #(
        .WIDTH(16),
        .LEVEL_MAX(16'h7FFF)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .base_cutoff   (base_cutoff),
        .env_amount    (env_amount),
        .cutoff        (cutoff),
        .cutoff_valid  (cutoff_valid),
        .env_level     (env_level),
        .env_state     (env_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int lvl;
        int st;
    } ls_t;

    ls_t    sq[$];
    longint cq[$];
    ls_t    mon_e;
    int     cwait = 0;
    bit     mon_en = 1'b0;

    // Parameters the stimulus wants applied on the next driven cycle.
    logic [15:0] p_att = 16'h4000, p_dec = 16'h1000, p_sus = 16'h2000, p_rel = 16'h0800;
    logic [15:0] p_base = 16'h0000, p_amt = 16'h7FFF;
    bit          g_cur = 1'b1;

    // Reference model: 0=idle 1=attack 2=decay 3=sustain 4=release
    int m_st = 0;
    int m_lvl = 0;
    bit m_gprev = 1'b0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int down_step(input int lvl, input int tg, input int rate);
        int d;
        int s;
`ifdef FILTER_ENV_EXP_DECAY_EN
        d = (lvl > tg) ? lvl - tg : 0;
        s = (d * rate) >> 15;
        if (s < 1) s = 1;
`else
        d = 0;
        s = rate + d;
`endif
        return s;
    endfunction

    task automatic model_cycle(input bit g, input bit t);
        bit rise, fall;
        int sus, ra, nl;
        rise = g && !m_gprev;
        fall = !g && m_gprev;
        m_gprev = g;
        sus = int'($signed(p_sus));
        if (sus < 0) sus = 0;
        if (rise) begin
            m_st = 1;
        end else if (fall) begin
            if (m_st >= 1 && m_st <= 3) m_st = 4;
        end else if (t) begin
            case (m_st)
                0: m_lvl = 0;
                1: begin
                    ra = int'(p_att % 16'h8000);
                    if (ra != 0) begin
                        m_lvl = m_lvl + ra;
                        if (m_lvl >= 32767) begin
                            m_lvl = 32767;
                            m_st = 2;
                        end
                    end
                end
                2: begin
                    ra = int'(p_dec % 16'h8000);
                    if (ra != 0) begin
                        nl = m_lvl - down_step(m_lvl, sus, ra);
                        if (nl <= sus) begin
                            m_lvl = sus;
                            m_st = 3;
                        end else begin
                            m_lvl = nl;
                        end
                    end
                end
                3: m_lvl = sus;
                default: begin
                    ra = int'(p_rel % 16'h8000);
                    if (ra != 0) begin
                        nl = m_lvl - down_step(m_lvl, 0, ra);
                        if (nl <= 0) begin
                            m_lvl = 0;
                            m_st = 0;
                        end else begin
                            m_lvl = nl;
                        end
                    end
                end
            endcase
        end
    endtask

    function automatic longint exp_cutoff();
        longint p, v;
        p = longint'(m_lvl) * longint'($signed(p_amt));
        v = longint'($signed(p_base)) + (p >>> 15);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    // Applies one cycle of inputs; call right after a negedge.
    task automatic drive(input bit g, input bit t);
        ls_t e;
        gate = g;
        tick = t;
        attack_rate = p_att;
        decay_rate = p_dec;
        sustain_level = p_sus;
        release_rate = p_rel;
        base_cutoff = p_base;
        env_amount = p_amt;
        g_cur = g;
        model_cycle(g, t);
        e.lvl = m_lvl;
        e.st = m_st;
        sq.push_back(e);
        if (t) cq.push_back(exp_cutoff());
        mon_en = 1'b1;
    endtask

    task automatic step(input bit g, input bit t);
        @(negedge clk);
        drive(g, t);
    endtask

    // Modulation inputs only change in a window with no tick before or during it.
    task automatic set_mod(input logic [15:0] b, input logic [15:0] a);
        step(g_cur, 1'b0);
        p_base = b;
        p_amt = a;
        step(g_cur, 1'b0);
    endtask

    task automatic run_until(input bit g, input int st, input int budget);
        for (int i = 0; i < budget && m_st != st; i++) step(g, 1'b1);
    endtask

    function automatic logic [15:0] pick_rate();
        case ($urandom_range(0, 9))
            0:             return 16'h0000;
            1, 2, 3, 4, 5: return 16'($urandom_range(1, 1024));
            default:       return 16'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (sq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL level_queue: got no expectation, required one (t=%0t)", $time);
            end else begin
                mon_e = sq.pop_front();
                chk("env_level", longint'(env_level), longint'(mon_e.lvl));
                chk("env_state", longint'(env_state), longint'(mon_e.st));
            end
            if (cutoff_valid) begin
                if (cq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cutoff_valid_spurious: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    chk("cutoff", longint'(cutoff), cq.pop_front());
                end
                cwait = 0;
            end else if (cq.size() > 0) begin
                cwait++;
                if (cwait > 3) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cutoff_timeout: got no cutoff_valid, expected %0d", cq.pop_front());
                    cwait = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cutoff"}, longint'(cutoff), 0);
        chk({tag, "_valid"}, longint'(cutoff_valid), 0);
        chk({tag, "_level"}, longint'(env_level), 0);
        chk({tag, "_state"}, longint'(env_state), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        gate = 1'b1;
        tick = 1'b0;
        attack_rate = p_att;
        decay_rate = p_dec;
        sustain_level = p_sus;
        release_rate = p_rel;
        base_cutoff = p_base;
        env_amount = p_amt;

        // Reset with gate held high, then release: rising edge seen at next clk.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 1'b1);

        // Attack -> decay -> sustain with continuous ticks.
        run_until(1'b1, 3, 400);
        repeat (3) step(1'b1, 1'b1);

        // Release to idle.
        run_until(1'b0, 0, 400);
        repeat (2) step(1'b0, 1'b1);

        // Cutoff saturation, both directions; decay rate 0 parks the level at peak.
        set_mod(16'h7000, 16'h7FFF);
        p_dec = 16'h0000;
        step(1'b1, 1'b0);
        run_until(1'b1, 2, 20);
        repeat (3) step(1'b1, 1'b1);
        set_mod(16'h8000, 16'h8000);
        repeat (2) step(1'b1, 1'b1);

        // Retrigger from a mid-release level; edges coincide with ticks.
        set_mod(16'h0000, 16'h7FFF);
        p_dec = 16'h1000;
        p_sus = 16'h3000;
        p_rel = 16'h0400;
        run_until(1'b1, 3, 400);
        repeat (3) step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);

        // Release from 0x1000 with a large rate.
        p_sus = 16'h1000;
        p_dec = 16'h4000;
        run_until(1'b1, 3, 400);
        p_rel = 16'h4000;
        step(1'b0, 1'b1);
        run_until(1'b0, 0, 100);
        step(1'b0, 1'b1);

        // Asynchronous reset mid-envelope, gate high during release of reset.
        step(1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1);
        @(negedge clk);
        mon_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sq.delete();
        cq.delete();
        cwait = 0;
        m_st = 0;
        m_lvl = 0;
        m_gprev = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b1);

        // Randomized operation.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) set_mod(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 31) == 0) p_att = pick_rate();
            if ($urandom_range(0, 31) == 0) p_dec = pick_rate();
            if ($urandom_range(0, 31) == 0) p_rel = pick_rate();
            if ($urandom_range(0, 47) == 0) p_sus = 16'($urandom);
            step(($urandom_range(0, 39) == 0) ? ~g_cur : g_cur, $urandom_range(0, 9) < 6);
        end

        repeat (4) step(g_cur, 1'b0);
        @(posedge clk);
        #2;
        chk("cutoff_drain", longint'(cq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
